mpc_issue: RTL and testbench

MPC_ISSUE -- requirements
Module: mpc_issue

---
 rtl/mpc_pkg.sv | 24 ++
 rtl/mpc_issue_fifo.sv | 60 ++++++
 rtl/mpc_issue.sv | 127 ++++++++++++
 tb/tb_mpc_issue.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mpc_pkg
// Brief   : Shared widths and FSM encodings for the MPC issue block.
// Revision: 1.0 - initial release
// ============================================================================
package mpc_pkg;

    localparam int INSTR_W = 18;
    localparam int RES_W   = 9;
    localparam int TAG_W   = 3;

    localparam logic [1:0] C_ST_IDLE  = 2'd0;
    localparam logic [1:0] C_ST_DRIVE = 2'd1;
    localparam logic [1:0] C_ST_HOLD  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = C_ST_IDLE,
        ST_DRIVE = C_ST_DRIVE,
        ST_HOLD  = C_ST_HOLD
    } state_t;

endpackage : mpc_pkg
`default_nettype wire

// File: rtl/mpc_issue_fifo.sv
`default_nettype none
// ============================================================================
// Module  : mpc_issue_fifo
// Brief   : Power-of-two instruction queue; head word visible on rdata.
// Revision: 1.0 - initial release
// ============================================================================
module mpc_issue_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit separates full from empty when the indices match.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;
    assign rdata     = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, w_do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, w_do_pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule : mpc_issue_fifo
`default_nettype wire

// File: rtl/mpc_issue.sv
`default_nettype none
// ============================================================================
// Module  : mpc_issue
// Brief   : Queues instructions, drives a combinational MPC, returns tagged results.
// Revision: 1.0 - initial release
// ============================================================================
module mpc_issue #(
    parameter int DEPTH   = 8,
    parameter int INSTR_W = mpc_pkg::INSTR_W,
    parameter int RES_W   = mpc_pkg::RES_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [INSTR_W-1:0]        in_instr,
    output logic [INSTR_W-1:0]        mpc_instr,
    input  logic [RES_W-1:0]          mpc_out,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [RES_W-1:0]          res_data,
    output logic [mpc_pkg::TAG_W-1:0] res_tag,
    output logic                      busy
);

    import mpc_pkg::*;

    state_t             state_q, state_d;
    logic [INSTR_W-1:0] mpc_instr_q, mpc_instr_d;
    logic [RES_W-1:0]   res_data_q, res_data_d;
    logic               res_valid_q, res_valid_d;
    logic [TAG_W-1:0]   res_tag_q, res_tag_d;
    logic [TAG_W-1:0]   tag_cnt_q, tag_cnt_d;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic [INSTR_W-1:0] w_head;

    // Acceptance depends only on registered occupancy, never on a same-cycle pop.
    assign in_ready = ~w_full;
    assign w_push   = in_valid & ~w_full;

    mpc_issue_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (in_instr),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    always_comb begin
        state_d     = state_q;
        mpc_instr_d = mpc_instr_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        res_tag_d   = res_tag_q;
        tag_cnt_d   = tag_cnt_q;
        w_pop       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    mpc_instr_d = w_head;
                    state_d     = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                // mpc_instr has been stable for a full cycle, so mpc_out has settled.
                res_data_d  = mpc_out;
                res_valid_d = 1'b1;
                res_tag_d   = tag_cnt_q;
                tag_cnt_d   = tag_cnt_q + 1'b1;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        mpc_instr_d = w_head;
                        state_d     = ST_DRIVE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mpc_instr_q <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            res_tag_q   <= '0;
            tag_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            mpc_instr_q <= mpc_instr_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
            res_tag_q   <= res_tag_d;
            tag_cnt_q   <= tag_cnt_d;
        end
    end

    assign mpc_instr = mpc_instr_q;
    assign res_data  = res_data_q;
    assign res_valid = res_valid_q;
    assign res_tag   = res_tag_q;
    assign busy      = ~w_empty | (state_q != ST_IDLE);

endmodule : mpc_issue
`default_nettype wire

// File: tb/tb_mpc_issue.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_mpc_issue
// Brief   : Directed and random stimulus against a queue-level issue model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mpc_issue;

    localparam int DEPTH = 8;
    localparam int IW    = 18;
    localparam int RW    = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_instr;
    logic [IW-1:0] mpc_instr;
    logic [RW-1:0] mpc_out;
    logic          res_valid;
    logic          res_ready;
    logic [RW-1:0] res_data;
    logic [2:0]    res_tag;
    logic          busy;
    logic [RW-1:0] noise = '0;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    function automatic logic [RW-1:0] f_mpc(input logic [IW-1:0] x);
        return x[8:0] ^ x[17:9] ^ 9'h0A5;
    endfunction

    // MPC model: correct only while the issued word has had its full cycle to settle.
    assign mpc_out = f_mpc(mpc_instr) ^ noise;

    mpc_issue #(.DEPTH(DEPTH), .INSTR_W(IW), .RES_W(RW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .mpc_instr (mpc_instr),
        .mpc_out   (mpc_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_tag   (res_tag),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a word queue plus one issue slot whose age says whether its result is out yet.
    logic [IW-1:0] m_q[$];
    bit            m_started = 1'b0;
    bit            m_slot = 1'b0;
    int            m_age = 0;
    logic [IW-1:0] m_slot_instr = '0;
    logic [IW-1:0] m_instr = '0;
    int            m_caps = 0;
    logic [RW-1:0] m_last_data = '0;
    logic [2:0]    m_last_tag = '0;
    int            cycle = 0;
    int            del_count = 0;
    int            del_cycle[$];
    logic [2:0]    del_tag[$];
    logic [IW-1:0] del_instr[$];
    bit            m_rv, m_hs, m_pop, m_push;

    initial begin
        forever begin
            @(posedge clk);
            cycle++;
            if (rst) begin
                m_q.delete();
                m_slot      = 1'b0;
                m_age       = 0;
                m_instr     = '0;
                m_caps      = 0;
                m_last_data = '0;
                m_last_tag  = '0;
                m_started   = 1'b1;
            end else begin
                m_rv   = m_slot && (m_age >= 1);
                m_hs   = m_rv && res_ready;
                m_push = in_valid && (m_q.size() < DEPTH);
                m_pop  = (m_q.size() > 0) && (!m_slot || m_hs);
                if (m_slot && m_age == 0) begin
                    m_last_data = f_mpc(m_slot_instr);
                    m_last_tag  = 3'(m_caps % 8);
                    m_caps++;
                end
                if (m_slot && m_age < 2) m_age++;
                if (m_hs) begin
                    m_slot = 1'b0;
                    del_count++;
                    del_cycle.push_back(cycle);
                    del_tag.push_back(m_last_tag);
                    del_instr.push_back(m_slot_instr);
                end
                if (m_pop) begin
                    m_slot_instr = m_q.pop_front();
                    m_instr      = m_slot_instr;
                    m_slot       = 1'b1;
                    m_age        = 0;
                end
                if (m_push) m_q.push_back(in_instr);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            noise = (m_slot && m_age == 0) ? '0 : RW'($urandom);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_started) begin
                check("in_ready",  32'(in_ready),  32'(m_q.size() < DEPTH));
                check("res_valid", 32'(res_valid), 32'(m_slot && m_age >= 1));
                check("busy",      32'(busy),      32'(m_q.size() != 0 || m_slot));
                check("mpc_instr", 32'(mpc_instr), 32'(m_instr));
                check("res_data",  32'(res_data),  32'(m_last_data));
                check("res_tag",   32'(res_tag),   32'(m_last_tag));
            end
        end
    end

    task automatic clear_log();
        del_count = 0;
        del_cycle.delete();
        del_tag.delete();
        del_instr.delete();
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        clear_log();
    endtask

    task automatic wait_del(input int n, input int budget, input string name);
        int k = 0;
        while (del_count < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(del_count), 32'(n));
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("drain_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [IW-1:0] sent[$];
        int            cnt_before;
        int            room;

        rst = 1'b1; in_valid = 1'b0; in_instr = '0; res_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_log();
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_mpc_instr", 32'(mpc_instr), 32'd0);
        check("rst_res_data",  32'(res_data),  32'd0);
        check("rst_res_tag",   32'(res_tag),   32'd0);

        // First-word latency, then hold the result while the MPC output wanders.
        in_valid = 1'b1; in_instr = 18'h00701;
        @(negedge clk);
        in_valid = 1'b0;
        check("lat_no_bypass", 32'(mpc_instr), 32'd0);
        @(negedge clk);
        check("lat_instr", 32'(mpc_instr), 32'h00701);
        check("lat_rv_early", 32'(res_valid), 32'd0);
        @(negedge clk);
        check("lat_rv", 32'(res_valid), 32'd1);
        check("lat_data", 32'(res_data), 32'h1A7);
        check("lat_tag", 32'(res_tag), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_data", 32'(res_data), 32'h1A7);
            check("hold_instr", 32'(mpc_instr), 32'h00701);
        end

        // Fill the queue behind the held result; the ninth offer must be dropped.
        sent.delete();
        sent.push_back(18'h00701);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_instr = IW'($urandom);
            sent.push_back(in_instr);
            @(negedge clk);
        end
        check("full_in_ready", 32'(in_ready), 32'd0);
        in_instr = 18'h3FFFF;
        @(negedge clk);
        in_valid  = 1'b0;
        res_ready = 1'b1;
        wait_del(9, 60, "full_deliveries");
        repeat (4) @(negedge clk);
        check("full_no_ninth", 32'(del_count), 32'd9);
        for (int i = 0; i < 9; i++) begin
            if (i < del_instr.size()) check("full_order", 32'(del_instr[i]), 32'(sent[i]));
        end
        wait_idle(20);

        // Streaming: one result every other cycle, tags wrap after 7.
        do_reset();
        res_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_instr = IW'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        wait_del(10, 60, "stream_deliveries");
        for (int i = 0; i < 10 && i < del_tag.size(); i++) begin
            check("stream_tag", 32'(del_tag[i]), 32'(i % 8));
            if (i > 0) check("stream_gap", 32'(del_cycle[i] - del_cycle[i-1]), 32'd2);
        end
        wait_idle(20);

        // Reset while holding a result with three words queued.
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_instr = IW'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_rv", 32'(res_valid), 32'd1);
        do_reset();
        check("mid_rst_rv", 32'(res_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        res_ready = 1'b1;
        cnt_before = del_count;
        repeat (10) @(negedge clk);
        check("mid_rst_nothing", 32'(del_count), 32'(cnt_before));

        // Push and pop on the same edge at occupancy four.
        do_reset();
        res_ready = 1'b0;
        sent.delete();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_instr = IW'($urandom);
            sent.push_back(in_instr);
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        res_ready = 1'b1; in_valid = 1'b1; in_instr = IW'($urandom);
        sent.push_back(in_instr);
        @(negedge clk);
        res_ready = 1'b0;
        room = 0;
        while (in_ready && room < 10) begin
            in_instr = IW'($urandom);
            sent.push_back(in_instr);
            @(negedge clk);
            room++;
        end
        in_valid = 1'b0;
        check("occ_room", 32'(room), 32'd4);
        res_ready = 1'b1;
        wait_del(10, 60, "occ_deliveries");
        for (int i = 0; i < 10 && i < del_instr.size(); i++) begin
            check("occ_order", 32'(del_instr[i]), 32'(sent[i]));
        end
        wait_idle(20);

        // Random traffic with occasional resets; the compare process does the checking.
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 299) == 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            in_instr  = IW'($urandom);
            res_ready = (i % 200 < 60) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
        rst = 1'b0; in_valid = 1'b0; res_ready = 1'b1;
        wait_idle(40);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_mpc_issue
`default_nettype wire
